// File: rtl/uart_pkg.sv
// Shared frame constants, scheduler state encoding and sizing helpers for the UART TX path.
package uart_pkg;

    localparam int unsigned FRAME_BITS = 10;
    localparam logic [3:0]  START_IDX  = 4'd0;
    localparam logic [3:0]  STOP_IDX   = 4'(FRAME_BITS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } sched_state_e;

    // Width of a counter that must reach baud_cnt-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned baud_cnt);
        return (baud_cnt <= 2) ? 1 : $clog2(baud_cnt);
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority encoder: first set req bit after ptr, wrapping modulo N_REQ.
module uart_rr_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         grant_onehot,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(N_REQ);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        idx          = '0;
        found        = 1'b0;
        for (int k = 1; k <= int'(N_REQ); k++) begin
            idx = IW'((32'(ptr) + 32'(k)) % N_REQ);
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_idx         = idx;
                grant_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates N_REQ byte producers onto one uart_tx driver and sequences each 10-bit frame.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned N_REQ    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       req_data,
    output logic [N_REQ-1:0]         ack,
    output logic                     done,
    output logic [$clog2(N_REQ)-1:0] done_id,
    output logic                     busy,
    output logic [3:0]               tx_num,
    output logic                     tx_sel_data,
    output logic [7:0]               data_out
);

    localparam int unsigned BAUD_CNT = CLK_FREQ / BAUD;
    localparam int unsigned CW       = cnt_width(BAUD_CNT);
    localparam int unsigned IW       = $clog2(N_REQ);
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT - 1);

    generate
        if (BAUD_CNT < 2 || N_REQ < 2 || N_REQ > 8) begin : g_param_err
            $error("uart_tx_sched: need CLK_FREQ/BAUD >= 2 and N_REQ in 2..8");
        end
    endgenerate

    sched_state_e   state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     tx_num_q, tx_num_d;
    logic           sel_q, sel_d;
    logic           busy_q, busy_d;
    logic [7:0]     data_q, data_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic           done_q, done_d;
    logic [IW-1:0]  done_id_q, done_id_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  id_q, id_d;

    logic [N_REQ-1:0] grant_onehot;
    logic [IW-1:0]    grant_idx;

    uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req          (req),
        .ptr          (ptr_q),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tx_num_q  <= START_IDX;
            sel_q     <= 1'b0;
            busy_q    <= 1'b0;
            data_q    <= '0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            ptr_q     <= IW'(N_REQ - 1);
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tx_num_q  <= tx_num_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
        end
    end

    // Capture in IDLE only; in SEND each tx_num is held for BAUD_CNT clocks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_num_d  = tx_num_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        data_d    = data_q;
        ack_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        ptr_d     = ptr_q;
        id_d      = id_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req != '0) begin
                    data_d   = req_data[{grant_idx, 3'b000} +: 8];
                    ack_d    = grant_onehot;
                    ptr_d    = grant_idx;
                    id_d     = grant_idx;
                    busy_d   = 1'b1;
                    sel_d    = 1'b1;
                    tx_num_d = START_IDX;
                    cnt_d    = '0;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (tx_num_q < STOP_IDX) begin
                        tx_num_d = 4'(tx_num_q + 4'd1);
                    end else begin
                        // tx_num stays at the stop index so the line idles high.
                        sel_d     = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                        done_id_d = id_q;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ack         = ack_q;
    assign done        = done_q;
    assign done_id     = done_id_q;
    assign busy        = busy_q;
    assign tx_num      = tx_num_q;
    assign tx_sel_data = sel_q;
    assign data_out    = data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed scenarios plus random requests, checked each cycle against a frame-level model.
module tb_uart_tx_sched;

    localparam int NR    = 4;
    localparam int BCNT  = 16;
    localparam int FRAME = 10 * BCNT;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   ack;
    logic            done;
    logic [1:0]      done_id;
    logic            busy;
    logic [3:0]      tx_num;
    logic            tx_sel_data;
    logic [7:0]      data_out;
    logic            line;

    uart_tx_sched #(.CLK_FREQ(1600), .BAUD(100), .N_REQ(NR)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .ack         (ack),
        .done        (done),
        .done_id     (done_id),
        .busy        (busy),
        .tx_num      (tx_num),
        .tx_sel_data (tx_sel_data),
        .data_out    (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Minimal uart_tx stand-in: drives the frame bit selected by tx_num, one clock late.
    always @(posedge clk or posedge rst) begin
        if (rst) line <= 1'b1;
        else if (tx_sel_data) begin
            if (tx_num == 4'd0) line <= 1'b0;
            else if (tx_num >= 4'd9) line <= 1'b1;
            else line <= data_out[tx_num - 4'd1];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: time since capture decides everything.
    int        m_busy, m_t, m_ptr, m_id, m_txn, e_done_id;
    logic [7:0] m_data;
    logic [NR-1:0] e_ack;
    logic      e_done;

    task automatic model_reset();
        m_busy = 0; m_t = 0; m_ptr = NR - 1; m_id = 0; m_txn = 0;
        m_data = 8'h00; e_done_id = 0; e_ack = '0; e_done = 1'b0;
    endtask

    task automatic model_step();
        int g;
        e_ack  = '0;
        e_done = 1'b0;
        if (rst) begin
            model_reset();
        end else if (m_busy == 0) begin
            if (req != '0) begin
                g = -1;
                for (int k = 1; k <= NR; k++)
                    if (g < 0 && req[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
                e_ack[g] = 1'b1;
                m_ptr = g; m_id = g; m_data = req_data[8*g +: 8];
                m_busy = 1; m_t = 0; m_txn = 0;
            end
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_busy = 0; e_done = 1'b1; e_done_id = m_id;
            end else begin
                m_txn = m_t / BCNT;
            end
        end
    endtask

    int cyc = 0, rel = 0, sel_cnt = 0;
    int ack_log[$], ack_cyc[$], done_log[$], done_cyc[$];
    logic line_q[$];

    task automatic clear_logs();
        ack_log.delete(); ack_cyc.delete(); done_log.delete(); done_cyc.delete(); line_q.delete();
        sel_cnt = 0;
    endtask

    // One clock: model advances on the edge, DUT sampled 1 time unit later, inputs change on negedge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("ack", 32'(ack), 32'(e_ack));
        check_eq("done", 32'(done), 32'(e_done));
        check_eq("done_id", 32'(done_id), 32'(e_done_id));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("tx_sel_data", 32'(tx_sel_data), 32'(m_busy));
        check_eq("tx_num", 32'(tx_num), 32'(m_txn));
        check_eq("data_out", 32'(data_out), 32'(m_data));
        cyc++;
        rel++;
        for (int i = 0; i < NR; i++)
            if (ack[i]) begin ack_log.push_back(i); ack_cyc.push_back(cyc); rel = 0; end
        if (tx_sel_data) sel_cnt++;
        if (tx_sel_data && (rel % BCNT) == BCNT / 2) line_q.push_back(line);
        if (done) begin done_log.push_back(int'(done_id)); done_cyc.push_back(cyc); end
        @(negedge clk);
    endtask

    task automatic wait_ack(input string tag, input int idx, input int budget);
        int n = 0;
        do begin cycle(); n++; end while (!ack[idx] && n < budget);
        check_eq(tag, 32'(ack[idx]), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin cycle(); n++; end while (!done && n < budget);
        check_eq(tag, 32'(done), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ack"}, 32'(ack), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_done_id"}, 32'(done_id), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_tx_num"}, 32'(tx_num), 32'd0);
        check_eq({tag, "_sel"}, 32'(tx_sel_data), 32'd0);
        check_eq({tag, "_data_out"}, 32'(data_out), 32'd0);
    endtask

    initial begin
        logic [9:0] exp_line;
        int n;
        int rr_exp[5];

        rst = 1'b1;
        req = '0;
        req_data = '0;
        model_reset();
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // Round robin from the reset pointer.
        clear_logs();
        req_data = 32'h44332211;
        req = 4'b1111;
        n = 0;
        while (ack_log.size() < 5 && n < 1200) begin cycle(); n++; end
        check_eq("rr_ack_count", 32'(ack_log.size()), 32'd5);
        req = '0;
        wait_done("rr_drain", 2 * FRAME);
        rr_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < ack_log.size()) check_eq("rr_order", 32'(ack_log[i]), 32'(rr_exp[i]));
            if (i < done_log.size()) check_eq("rr_done_id", 32'(done_log[i]), 32'(rr_exp[i]));
        end
        for (int i = 0; i < 4; i++)
            if (i + 1 < ack_cyc.size() && i < done_cyc.size())
                check_eq("rr_gap", 32'(ack_cyc[i+1] - done_cyc[i]), 32'd1);

        // Single byte with line decoding.
        repeat (3) cycle();
        clear_logs();
        req_data = {24'($urandom), 8'hA5};
        req = 4'b0001;
        wait_ack("single_ack", 0, 10);
        check_eq("single_ack_lat", 32'(ack_cyc.size() > 0 ? ack_cyc[0] - (cyc - 1) : -1), 32'd1);
        cycle();
        req = '0;
        req_data[7:0] = 8'($urandom);
        wait_done("single_done", 2 * FRAME);
        check_eq("single_done_id", 32'(done_id), 32'd0);
        check_eq("single_sel_cycles", 32'(sel_cnt), 32'(FRAME));
        check_eq("single_line_bits", 32'(line_q.size()), 32'd10);
        exp_line = 10'b1101001010;
        for (int i = 0; i < 10; i++)
            if (i < line_q.size()) check_eq("single_line", 32'(line_q[i]), 32'(exp_line[i]));

        // Pointer wrap: grant 2, then 0011 yields 0 then 1.
        repeat (2) cycle();
        clear_logs();
        req_data = 32'hD4C3B2A1;
        req = 4'b0100;
        wait_ack("wrap_ack2", 2, 10);
        req = 4'b0011;
        wait_ack("wrap_ack0", 0, 2 * FRAME);
        wait_ack("wrap_ack1", 1, 2 * FRAME);
        check_eq("wrap_order_n", 32'(ack_log.size()), 32'd3);
        if (ack_log.size() == 3) begin
            check_eq("wrap_order0", 32'(ack_log[1]), 32'd0);
            check_eq("wrap_order1", 32'(ack_log[2]), 32'd1);
        end

        // Mid-frame request from 3 waits for frame end.
        req = '0;
        clear_logs();
        n = 0;
        while (tx_num != 4'd4 && n < FRAME) begin cycle(); n++; end
        req_data[31:24] = 8'h5A;
        req = 4'b1000;
        wait_done("mid_done", 2 * FRAME);
        cycle();
        check_eq("mid_ack3", 32'(ack[3]), 32'd1);
        check_eq("mid_ack_n", 32'(ack_log.size()), 32'd1);
        if (ack_cyc.size() == 1 && done_cyc.size() == 1)
            check_eq("mid_ack_after_done", 32'(ack_cyc[0] - done_cyc[0]), 32'd1);
        req = '0;

        // Asynchronous reset mid-frame, then pointer back at N_REQ-1.
        clear_logs();
        n = 0;
        while (tx_num != 4'd5 && n < FRAME) begin cycle(); n++; end
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        check_eq("rst_no_done", 32'(done_log.size()), 32'd0);
        req_data = 32'h9988_7766;
        req = 4'b1100;
        cycle();
        check_eq("rst_first_grant", 32'(ack), 32'b0100);
        req = '0;

        // Withdrawn request during busy.
        clear_logs();
        repeat (20) cycle();
        req = 4'b0010;
        repeat (5) cycle();
        req = '0;
        wait_done("wd_done", 2 * FRAME);
        repeat (40) cycle();
        check_eq("wd_no_ack", 32'(ack_log.size()), 32'd0);
        check_eq("wd_busy", 32'(busy), 32'd0);
        check_eq("wd_one_done", 32'(done_log.size()), 32'd1);

        // Random request traffic.
        for (int c = 0; c < 6000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req[i] || ack[i]) req_data[8*i +: 8] = 8'($urandom);
                if ($urandom_range(0, 15) == 0) req[i] = ~req[i];
            end
            cycle();
        end
        req = '0;
        n = 0;
        while (busy && n < 2 * FRAME) begin cycle(); n++; end
        check_eq("final_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
